// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI control unit.
// Holds the FSM encoding and the control-word bit map.
package spi_pkg;

   localparam int CNT_W_MAX = 8;
   localparam int N_CS_MAX  = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT
   } state_t;

   localparam int BIT_SEND    = 0;
   localparam int BIT_CS_CTRL = 1;
   localparam int BIT_ALL_1S  = 2;
   localparam int BIT_ALL_0S  = 3;
   localparam int BIT_NTX     = 4;
   localparam int BIT_CS_SEL  = 12;
   localparam int BIT_DONE    = 14;
   localparam int BIT_ERR     = 15;
   localparam int BIT_NRX     = 16;
   localparam int BIT_IRQ_EN  = 29;
   localparam int BIT_BUSY    = 30;

endpackage

// File: rtl/spi_ctrl_unit_if.sv
// Host/engine-facing bundle of the SPI control unit.
// slave is the control unit side, master the driver side.
interface spi_ctrl_unit_if #(
   parameter int CNT_W = 6,
   parameter int N_CS  = 4
);
   logic [31:0]      i_data;
   logic             wr_ctrl;
   logic             wr_send;
   logic             xfer_done;
   logic [CNT_W:0]   n_rx_end;
   logic             xfer_start;
   logic             send;
   logic             busy;
   logic             all_1s;
   logic             all_0s;
   logic             irq;
   logic [CNT_W-1:0] n_tx_end;
   logic [N_CS-1:0]  cs_n;
   logic [31:0]      out_ctrl;

   modport slave (
      input  i_data, wr_ctrl, wr_send,
      input  xfer_done, n_rx_end,
      output xfer_start, send, busy,
      output all_1s, all_0s, irq,
      output n_tx_end, cs_n, out_ctrl
   );

   modport master (
      output i_data, wr_ctrl, wr_send,
      output xfer_done, n_rx_end,
      input  xfer_start, send, busy,
      input  all_1s, all_0s, irq,
      input  n_tx_end, cs_n, out_ctrl
   );
endinterface

// File: rtl/spi_cs_decode.sv
// Registered one-hot active-low chip-select decoder.
// A select index beyond N_CS leaves every line high.
module spi_cs_decode #(
   parameter int N_CS = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      cs_sel,
   input  logic            en,
   output logic [N_CS-1:0] cs_n
);

   logic [N_CS-1:0] nxt;

   always_comb begin
      nxt = '1;
      for (int k = 0; k < N_CS; k++)
         if (en && cs_sel == 2'(k))
            nxt[k] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) cs_n <= '1;
      else     cs_n <= nxt;
   end

endmodule

// File: rtl/spi_ctrl_unit.sv
// SPI control/status register with start/wait sequencing
// towards the SPI engine and chip-select generation.
module spi_ctrl_unit
   import spi_pkg::*;
#(
   parameter int CNT_W = 6,
   parameter int N_CS  = 4
) (
   input logic           clk,
   input logic           rst,
   spi_ctrl_unit_if.slave bus
);

   state_t           state;
   logic             send;
   logic             cs_ctrl;
   logic             all_1s;
   logic             all_0s;
   logic             done;
   logic             err;
   logic             irq_en;
   logic             irq_q;
   logic             start_q;
   logic [CNT_W-1:0] n_tx;
   logic [1:0]       cs_sel;
   logic [CNT_W:0]   n_rx;
   logic [N_CS-1:0]  cs_n;
   logic [31:0]      ctrl;
   logic             idle;
   logic             busy;
   logic             fin;
   logic             wr_any;

   assign idle   = state == ST_IDLE;
   assign busy   = !idle;
   assign fin    = bus.xfer_done && busy;
   assign wr_any = bus.wr_ctrl || bus.wr_send;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         send    <= 1'b0;
         cs_ctrl <= 1'b0;
         all_1s  <= 1'b0;
         all_0s  <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         irq_en  <= 1'b0;
         irq_q   <= 1'b0;
         start_q <= 1'b0;
         n_tx    <= '0;
         cs_sel  <= '0;
         n_rx    <= '0;
      end else begin
         start_q <= 1'b0;
         irq_q   <= done && irq_en;
         unique case (state)
            ST_IDLE: begin
               if (send) begin
                  state   <= ST_START;
                  start_q <= 1'b1;
               end
            end
            ST_START: state <= fin ? ST_IDLE : ST_WAIT;
            ST_WAIT:  if (fin) state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
         if (idle && bus.wr_ctrl) begin
            send    <= bus.i_data[BIT_SEND];
            cs_ctrl <= bus.i_data[BIT_CS_CTRL];
            all_1s  <= bus.i_data[BIT_ALL_1S];
            all_0s  <= bus.i_data[BIT_ALL_0S];
            n_tx    <= bus.i_data[BIT_NTX +: CNT_W];
            cs_sel  <= bus.i_data[BIT_CS_SEL +: 2];
            irq_en  <= bus.i_data[BIT_IRQ_EN];
         end
         if (idle && bus.wr_send)
            send <= 1'b1;
         // clears first so that later sets win on collision
         if (bus.wr_ctrl && bus.i_data[BIT_DONE])
            done <= 1'b0;
         if (bus.wr_ctrl && bus.i_data[BIT_ERR])
            err <= 1'b0;
         if (busy && wr_any)
            err <= 1'b1;
         if (fin) begin
            send <= 1'b0;
            done <= 1'b1;
            n_rx <= bus.n_rx_end;
         end
      end
   end

   spi_cs_decode #(.N_CS(N_CS)) u_cs (
      .clk    (clk),
      .rst    (rst),
      .cs_sel (cs_sel),
      .en     (cs_ctrl || busy),
      .cs_n   (cs_n)
   );

   always_comb begin
      ctrl                        = '0;
      ctrl[BIT_SEND]              = send;
      ctrl[BIT_CS_CTRL]           = cs_ctrl;
      ctrl[BIT_ALL_1S]            = all_1s;
      ctrl[BIT_ALL_0S]            = all_0s;
      ctrl[BIT_NTX +: CNT_W]      = n_tx;
      ctrl[BIT_CS_SEL +: 2]       = cs_sel;
      ctrl[BIT_DONE]              = done;
      ctrl[BIT_ERR]               = err;
      ctrl[BIT_NRX +: CNT_W + 1]  = n_rx;
      ctrl[BIT_IRQ_EN]            = irq_en;
      ctrl[BIT_BUSY]              = busy;
   end

   assign bus.xfer_start = start_q;
   assign bus.send       = send;
   assign bus.busy       = busy;
   assign bus.all_1s     = all_1s;
   assign bus.all_0s     = all_0s;
   assign bus.irq        = irq_q;
   assign bus.n_tx_end   = n_tx;
   assign bus.cs_n       = cs_n;
   assign bus.out_ctrl   = ctrl;

endmodule

// File: tb/tb_spi_ctrl_unit.sv
// Scoreboard bench for spi_ctrl_unit: stimulus queues expected
// values per cycle, a negedge monitor pops and compares them.
module tb_spi_ctrl_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_ctrl_unit_if #(.CNT_W(6), .N_CS(4)) bus ();
   spi_ctrl_unit_if #(.CNT_W(6), .N_CS(2)) bus2 ();

   spi_ctrl_unit #(.CNT_W(6), .N_CS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   spi_ctrl_unit #(.CNT_W(6), .N_CS(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t        exp_q[$];
   int          start_q[$];
   int          cyc_cnt = 0;
   int          n_vec   = 0;
   int          n_bad   = 0;
   int          e_cyc;
   logic [31:0] act;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   function automatic logic [31:0] peek(int sel);
      case (sel)
         0:       return bus.out_ctrl;
         1:       return 32'(bus.cs_n);
         2:       return 32'(bus.busy);
         3:       return 32'(bus.irq);
         4:       return 32'(bus.xfer_start);
         5:       return 32'(bus.send);
         6:       return 32'(bus.n_tx_end);
         7:       return 32'(bus2.cs_n);
         8:       return 32'(bus.all_1s);
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   function automatic void chk(int dly, int sel,
                               logic [31:0] v, string nm);
      exp_q.push_back('{cyc_cnt + dly, sel, v, nm});
   endfunction

   always @(negedge clk) begin
      if (bus.xfer_start === 1'b1) begin
         n_vec++;
         if (start_q.size() == 0) begin
            n_bad++;
            $display("FAIL start_unexpected: xfer_start at cycle %0d, none required",
                     cyc_cnt);
         end else begin
            e_cyc = start_q.pop_front();
            if (e_cyc != cyc_cnt) begin
               n_bad++;
               $display("FAIL start_cycle: got cycle %0d, required %0d",
                        cyc_cnt, e_cyc);
            end
         end
      end
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].cyc == cyc_cnt) begin
            n_vec++;
            act = peek(exp_q[i].sel);
            if (act !== exp_q[i].val) begin
               n_bad++;
               $display("FAIL %s: got %h, required %h",
                        exp_q[i].name, act, exp_q[i].val);
            end
            exp_q.delete(i);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_ctrl(logic [31:0] d);
      bus.i_data  = d;
      bus.wr_ctrl = 1'b1;
      step();
      bus.wr_ctrl = 1'b0;
   endtask

   task automatic pulse_send();
      bus.wr_send = 1'b1;
      step();
      bus.wr_send = 1'b0;
   endtask

   task automatic pulse_done(logic [6:0] n);
      bus.n_rx_end  = n;
      bus.xfer_done = 1'b1;
      step();
      bus.xfer_done = 1'b0;
   endtask

   initial begin
      bus.i_data     = '0;
      bus.wr_ctrl    = 1'b0;
      bus.wr_send    = 1'b0;
      bus.xfer_done  = 1'b0;
      bus.n_rx_end   = '0;
      bus2.i_data    = '0;
      bus2.wr_ctrl   = 1'b0;
      bus2.wr_send   = 1'b0;
      bus2.xfer_done = 1'b0;
      bus2.n_rx_end  = '0;
      repeat (3) step();

      // reset state and quiet release
      chk(0, 0, 32'h0, "rst_ctrl");
      chk(0, 1, 32'hF, "rst_csn");
      chk(0, 2, 32'h0, "rst_busy");
      chk(0, 3, 32'h0, "rst_irq");
      chk(0, 7, 32'h3, "rst_csn2");
      chk(1, 4, 32'h0, "rel_no_start1");
      chk(2, 4, 32'h0, "rel_no_start2");
      rst = 1'b0;
      step();
      step();

      // start via wr_ctrl with send bit
      chk(1, 0, 32'h0000_0061, "t1_cfg");
      chk(1, 6, 32'd6, "t1_ntx");
      chk(2, 2, 32'h1, "t1_busy");
      chk(2, 0, 32'h4000_0061, "t1_busy_rd");
      chk(3, 4, 32'h0, "t1_start_1cyc");
      chk(3, 1, 32'hE, "t1_csn");
      start_q.push_back(cyc_cnt + 2);
      pulse_ctrl(32'h0000_0061);
      repeat (3) step();

      // completion in WAIT
      chk(1, 0, 32'h0006_4060, "t2_ctrl");
      chk(1, 2, 32'h0, "t2_busy");
      chk(1, 5, 32'h0, "t2_send");
      chk(2, 1, 32'hF, "t2_csn_rel");
      chk(3, 3, 32'h0, "t2_irq_off");
      pulse_done(7'd6);
      repeat (2) step();
      chk(1, 0, 32'h0006_4060, "t2_idle_done_ign");
      pulse_done(7'd9);

      // writes while busy raise err, leave config alone
      chk(2, 0, 32'h4006_4061, "t3_busy_rd");
      start_q.push_back(cyc_cnt + 2);
      pulse_send();
      step();
      chk(1, 0, 32'h4006_C061, "t3_err");
      pulse_send();
      chk(1, 0, 32'h4006_C061, "t3_cfg_locked");
      chk(1, 6, 32'd6, "t3_ntx_locked");
      pulse_ctrl(32'h0000_00F0);
      chk(1, 0, 32'h0003_C060, "t3_done");
      pulse_done(7'd3);
      chk(1, 0, 32'h0003_4000, "t3_err_clr");
      pulse_ctrl(32'h0000_8000);

      // done set beats coincident W1C clear, irq follows
      chk(1, 0, 32'h2003_0021, "t4_cfg");
      start_q.push_back(cyc_cnt + 2);
      pulse_ctrl(32'h2000_4021);
      repeat (2) step();
      chk(1, 0, 32'h2005_C020, "t4_done_wins");
      chk(2, 3, 32'h1, "t4_irq");
      bus.n_rx_end  = 7'd5;
      bus.xfer_done = 1'b1;
      bus.i_data    = 32'h2000_4000;
      bus.wr_ctrl   = 1'b1;
      step();
      bus.xfer_done = 1'b0;
      bus.wr_ctrl   = 1'b0;
      step();

      // reset mid-transfer
      chk(1, 0, 32'h0005_0031, "t5_cfg");
      start_q.push_back(cyc_cnt + 2);
      pulse_ctrl(32'h0000_C031);
      repeat (2) step();
      chk(1, 0, 32'h0, "t5_rst_ctrl");
      chk(1, 1, 32'hF, "t5_rst_csn");
      chk(1, 2, 32'h0, "t5_rst_busy");
      chk(1, 3, 32'h0, "t5_rst_irq");
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk(1, 0, 32'h0, "t5_done_ign");
      pulse_done(7'd7);
      repeat (3) step();

      // software chip select, out-of-range select
      chk(1, 0, 32'h0000_2006, "t6_ctrl");
      chk(1, 8, 32'h1, "t6_all1");
      chk(2, 1, 32'hB, "t6_csn_sel2");
      chk(2, 7, 32'h3, "t6_csn2_sel3");
      bus2.i_data  = 32'h0000_3002;
      bus2.wr_ctrl = 1'b1;
      pulse_ctrl(32'h0000_2006);
      bus2.wr_ctrl = 1'b0;
      chk(2, 7, 32'h1, "t6_csn2_sel1");
      chk(2, 1, 32'hB, "t6_csn_hold");
      bus2.i_data  = 32'h0000_1002;
      bus2.wr_ctrl = 1'b1;
      step();
      bus2.wr_ctrl = 1'b0;
      repeat (4) step();

      foreach (exp_q[i]) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s: never sampled, required %h",
                  exp_q[i].name, exp_q[i].val);
      end
      foreach (start_q[i]) begin
         n_vec++;
         n_bad++;
         $display("FAIL start_missing: got none, required cycle %0d",
                  start_q[i]);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
